axis_bram_pingpong_ctrl: RTL and testbench

//  Sequences a triggered AXIS->BRAM frame writer (trigger mode enabled) as a two-bank ping-pong capture.

---
 rtl/axis_bram_pkg.sv | 21 ++
 rtl/axis_frame_tracker.sv | 35 +++
 rtl/axis_bram_pingpong_ctrl.sv | 159 +++++++++++++++
 tb/tb_axis_bram_pingpong_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_bram_pkg.sv
// Shared types and defaults for the AXIS->BRAM ping-pong capture controller.
package axis_bram_pkg;

  localparam int unsigned LenWidthDef   = 16;
  localparam int unsigned CntWidthDef   = 16;
  localparam int unsigned FrameCntWidth = 32;

  typedef enum logic [2:0] {
    StIdle,
    StWaitBank,
    StTrig,
    StArmed,
    StCapture,
    StDrain
  } cap_state_t;

  function automatic logic [1:0] bank_onehot(input logic sel);
    return sel ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/axis_frame_tracker.sv
// Passive AXI-Stream tap: decodes handshake beats and tracks start-of-frame.
module axis_frame_tracker (
  input  logic aclk,
  input  logic aresetn,
  input  logic tvalid,
  input  logic tready,
  input  logic tlast,
  output logic beat,
  output logic last_beat,
  output logic at_sof
);

  logic at_sof_q, at_sof_d;

  // Starts cleared so a frame already in flight at reset is never taken as a start.
  always_comb begin
    at_sof_d = at_sof_q;
    if (beat) begin
      at_sof_d = tlast;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      at_sof_q <= 1'b0;
    end else begin
      at_sof_q <= at_sof_d;
    end
  end

  assign beat      = tvalid & tready;
  assign last_beat = beat & tlast;
  assign at_sof    = at_sof_q;

endmodule

// File: rtl/axis_bram_pingpong_ctrl.sv
// Two-bank ping-pong sequencer for a triggered AXIS->BRAM frame writer; bank_sel is the
// BRAM address MSB and only moves between frames.
module axis_bram_pingpong_ctrl
  import axis_bram_pkg::*;
#(
  parameter int unsigned LEN_WIDTH  = LenWidthDef,
  parameter int unsigned CNT_WIDTH  = CntWidthDef,
  parameter int unsigned NUM_FRAMES = 0
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 mon_tvalid,
  input  logic                 mon_tready,
  input  logic                 mon_tlast,
  input  logic                 arm,
  input  logic                 disarm,
  input  logic [1:0]           bank_release,
  output logic                 trigger_out,
  output logic                 bank_sel,
  output logic [1:0]           bank_full,
  output logic [LEN_WIDTH-1:0] bank_len0,
  output logic [LEN_WIDTH-1:0] bank_len1,
  output logic                 frame_irq,
  output logic [CNT_WIDTH-1:0] dropped_cnt,
  output logic                 busy
);

  logic beat, last_beat, at_sof;

  axis_frame_tracker u_tracker (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .tvalid    (mon_tvalid),
    .tready    (mon_tready),
    .tlast     (mon_tlast),
    .beat      (beat),
    .last_beat (last_beat),
    .at_sof    (at_sof)
  );

  cap_state_t               state_q, state_d;
  logic                     bank_sel_q, bank_sel_d;
  logic [1:0]               bank_full_q, bank_full_d;
  logic [LEN_WIDTH-1:0]     len_q, len_d;
  logic [LEN_WIDTH-1:0]     bank_len0_q, bank_len0_d;
  logic [LEN_WIDTH-1:0]     bank_len1_q, bank_len1_d;
  logic [CNT_WIDTH-1:0]     dropped_q, dropped_d;
  logic [FrameCntWidth-1:0] frames_left_q, frames_left_d;
  logic                     disarm_q, disarm_d;
  logic                     disarm_pend;
  logic [1:0]               set_mask;

  always_comb begin
    state_d       = state_q;
    bank_sel_d    = bank_sel_q;
    len_d         = len_q;
    bank_len0_d   = bank_len0_q;
    bank_len1_d   = bank_len1_q;
    dropped_d     = dropped_q;
    frames_left_d = frames_left_q;
    set_mask      = 2'b00;
    disarm_pend   = disarm_q | disarm;

    case (state_q)
      StIdle: begin
        if (arm && !disarm) begin
          state_d       = StWaitBank;
          frames_left_d = FrameCntWidth'(NUM_FRAMES);
        end
      end
      StWaitBank: begin
        if (last_beat && (dropped_q != '1)) begin
          dropped_d = dropped_q + CNT_WIDTH'(1);
        end
        if (disarm_pend) begin
          state_d = StIdle;
        end else if (!bank_full_q[bank_sel_q]) begin
          state_d = StTrig;
        end
      end
      // Once triggered the writer is committed to the next frame, so disarm only takes
      // effect after that frame drains.
      StTrig, StArmed: begin
        if (beat && at_sof) begin
          len_d   = LEN_WIDTH'(1);
          state_d = last_beat ? StDrain : StCapture;
        end else if (state_q == StTrig) begin
          state_d = StArmed;
        end
      end
      StCapture: begin
        if (beat) begin
          if (len_q != '1) begin
            len_d = len_q + LEN_WIDTH'(1);
          end
          if (last_beat) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        set_mask   = bank_onehot(bank_sel_q);
        bank_sel_d = ~bank_sel_q;
        if (bank_sel_q) begin
          bank_len1_d = len_q;
        end else begin
          bank_len0_d = len_q;
        end
        if (frames_left_q != '0) begin
          frames_left_d = frames_left_q - FrameCntWidth'(1);
        end
        if (disarm_pend || ((NUM_FRAMES != 0) && (frames_left_d == '0))) begin
          state_d = StIdle;
        end else begin
          state_d = StWaitBank;
        end
      end
      default: state_d = StIdle;
    endcase

    // A set in the same cycle as a release of that bank must win.
    bank_full_d = (bank_full_q & ~bank_release) | set_mask;
    disarm_d    = (state_d == StIdle) ? 1'b0 : disarm_pend;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q       <= StIdle;
      bank_sel_q    <= 1'b0;
      bank_full_q   <= 2'b00;
      len_q         <= '0;
      bank_len0_q   <= '0;
      bank_len1_q   <= '0;
      dropped_q     <= '0;
      frames_left_q <= '0;
      disarm_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      bank_sel_q    <= bank_sel_d;
      bank_full_q   <= bank_full_d;
      len_q         <= len_d;
      bank_len0_q   <= bank_len0_d;
      bank_len1_q   <= bank_len1_d;
      dropped_q     <= dropped_d;
      frames_left_q <= frames_left_d;
      disarm_q      <= disarm_d;
    end
  end

  assign trigger_out = (state_q == StTrig);
  assign frame_irq   = (state_q == StDrain);
  assign busy        = (state_q != StIdle);
  assign bank_sel    = bank_sel_q;
  assign bank_full   = bank_full_q;
  assign bank_len0   = bank_len0_q;
  assign bank_len1   = bank_len1_q;
  assign dropped_cnt = dropped_q;

endmodule

// File: tb/tb_axis_bram_pingpong_ctrl.sv
// Bench for the ping-pong capture controller with a behavioural triggered frame writer.
module tb_axis_bram_pingpong_ctrl;

  localparam int Gap = 4;

  typedef struct packed {
    logic            bank;
    logic [15:0]     len;
    logic [7:0][31:0] data;
  } exp_t;

  logic aclk, aresetn;
  logic tvalid, tready, tlast;
  logic [31:0] tdata;
  logic arm, disarm, arm2;
  logic [1:0] rel_man, rel_auto, rel2, bank_release;

  logic trig, sel, irq, busy;
  logic [1:0] full;
  logic [15:0] len0, len1, dropped;
  logic trig2, sel2, irq2, busy2;
  logic [1:0] full2;
  logic [15:0] len0_2, len1_2, dropped2;

  int checks = 0;
  int errors = 0;
  int trig_cnt = 0;
  int irq2_cnt = 0;
  bit auto_rel = 1'b1;
  logic next_bank = 1'b0;
  exp_t exp_q[$];
  exp_t cur;
  bit chk_pend = 1'b0;

  assign bank_release = rel_man | rel_auto;

  axis_bram_pingpong_ctrl #(.LEN_WIDTH(16), .CNT_WIDTH(16), .NUM_FRAMES(0)) dut (
    .aclk(aclk), .aresetn(aresetn), .mon_tvalid(tvalid), .mon_tready(tready),
    .mon_tlast(tlast), .arm(arm), .disarm(disarm), .bank_release(bank_release),
    .trigger_out(trig), .bank_sel(sel), .bank_full(full), .bank_len0(len0),
    .bank_len1(len1), .frame_irq(irq), .dropped_cnt(dropped), .busy(busy)
  );

  axis_bram_pingpong_ctrl #(.LEN_WIDTH(16), .CNT_WIDTH(16), .NUM_FRAMES(2)) dut2 (
    .aclk(aclk), .aresetn(aresetn), .mon_tvalid(tvalid), .mon_tready(tready),
    .mon_tlast(tlast), .arm(arm2), .disarm(1'b0), .bank_release(rel2),
    .trigger_out(trig2), .bank_sel(sel2), .bank_full(full2), .bank_len0(len0_2),
    .bank_len1(len1_2), .frame_irq(irq2), .dropped_cnt(dropped2), .busy(busy2)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Behavioural writer: arms on trigger, captures the next frame starting at address 0.
  logic [31:0] mem [512];
  logic w_armed, w_cap, w_sof;
  logic [7:0] w_addr;
  always @(posedge aclk) begin
    if (!aresetn) begin
      w_armed <= 1'b0; w_cap <= 1'b0; w_sof <= 1'b0; w_addr <= 8'd0;
    end else begin
      if (trig) w_armed <= 1'b1;
      if (tvalid && tready) begin
        w_sof <= tlast;
        if (w_cap) begin
          mem[{sel, w_addr}] <= tdata;
          w_addr <= w_addr + 8'd1;
          if (tlast) w_cap <= 1'b0;
        end else if ((w_armed || trig) && w_sof) begin
          mem[{sel, 8'd0}] <= tdata;
          w_addr  <= 8'd1;
          w_cap   <= !tlast;
          w_armed <= 1'b0;
        end
      end
    end
  end

  // Host emulation: release a bank the cycle after its irq.
  bit pend_m, pend_2;
  logic bank_m, bank_2;
  initial begin
    rel_auto = 2'b00; rel2 = 2'b00; pend_m = 1'b0; pend_2 = 1'b0; bank_m = 1'b0; bank_2 = 1'b0;
  end
  always @(negedge aclk) begin
    rel_auto = 2'b00;
    if (auto_rel && pend_m) rel_auto[bank_m] = 1'b1;
    pend_m = irq; bank_m = sel;
    rel2 = 2'b00;
    if (pend_2) rel2[bank_2] = 1'b1;
    pend_2 = irq2; bank_2 = sel2;
    if (irq2 === 1'b1) irq2_cnt++;
    if (trig === 1'b1) trig_cnt++;
  end

  // Scoreboard: pop on frame_irq, check bank contents and length one cycle later.
  always @(negedge aclk) begin
    bit ok;
    if (chk_pend) begin
      chk_pend = 1'b0;
      checks++;
      if ((cur.bank ? len1 : len0) !== cur.len) begin
        errors++;
        $display("FAIL sb_len: got %0d want %0d", cur.bank ? len1 : len0, cur.len);
      end
      checks++;
      if (full[cur.bank] !== 1'b1) begin
        errors++;
        $display("FAIL sb_full: got %b want bank %0d set", full, cur.bank);
      end
      ok = 1'b1;
      for (int k = 0; k < int'(cur.len); k++) begin
        if (mem[{cur.bank, k[7:0]}] !== cur.data[k]) ok = 1'b0;
      end
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL sb_data: bank %0d contents got mismatch want sent frame", cur.bank);
      end
    end
    if (irq === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_irq: got irq want none (bank_sel %b)", sel);
      end else begin
        cur = exp_q.pop_front();
        if (sel !== cur.bank) begin
          errors++;
          $display("FAIL sb_bank: got %b want %b", sel, cur.bank);
        end
        chk_pend = 1'b1;
      end
    end
  end

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic pulse_arm();
    arm = 1'b1; step(); arm = 1'b0; repeat (3) step();
  endtask

  task automatic send_frame(input int n, input bit cap, input int arm_at, input int disarm_at,
                            input bit stall);
    logic [7:0][31:0] d;
    exp_t e;
    int i;
    for (int j = 0; j < 8; j++) d[j] = $urandom;
    if (cap) begin
      e.bank = next_bank; e.len = 16'(n); e.data = d;
      exp_q.push_back(e);
      next_bank = ~next_bank;
    end
    i = 0;
    while (i < n) begin
      tready = !stall || ($urandom_range(3) != 0);
      tvalid = 1'b1;
      tdata  = d[i];
      tlast  = (i == n - 1);
      arm    = (i == arm_at);
      disarm = (i == disarm_at);
      step();
      if (tready) i++;
    end
    tvalid = 1'b0; tlast = 1'b0; tready = 1'b1; arm = 1'b0; disarm = 1'b0;
    repeat (Gap) step();
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    repeat (3) step();
    aresetn = 1'b1;
    checks++;
    if ({trig, sel, full, len0, len1, irq, dropped, busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0", {trig, sel, full, len0, len1, irq, dropped, busy});
    end
    checks++;
    if ({trig2, sel2, full2, irq2, busy2} !== '0) begin
      errors++;
      $display("FAIL reset_outputs2: got %b want 0", {trig2, sel2, full2, irq2, busy2});
    end
  endtask

  task automatic test_no_arm();
    for (int f = 0; f < 3; f++) send_frame(4, 1'b0, -1, -1, 1'b0);
    checks++;
    if (trig_cnt != 0) begin errors++; $display("FAIL noarm_trig: got %0d want 0", trig_cnt); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL noarm_busy: got %b want 0", busy); end
    checks++;
    if (dropped !== 16'd0) begin errors++; $display("FAIL noarm_drop: got %0d want 0", dropped); end
  endtask

  task automatic test_num_frames();
    arm2 = 1'b1; step(); arm2 = 1'b0; repeat (3) step();
    for (int f = 0; f < 5; f++) send_frame(8, 1'b0, -1, -1, 1'b0);
    checks++;
    if (irq2_cnt != 2) begin errors++; $display("FAIL nf_irqs: got %0d want 2", irq2_cnt); end
    checks++;
    if (len0_2 !== 16'd8 || len1_2 !== 16'd8) begin
      errors++; $display("FAIL nf_lens: got %0d/%0d want 8/8", len0_2, len1_2);
    end
    checks++;
    if (sel2 !== 1'b0) begin errors++; $display("FAIL nf_sel: got %b want 0", sel2); end
    checks++;
    if (busy2 !== 1'b0) begin errors++; $display("FAIL nf_busy: got %b want 0", busy2); end
    checks++;
    if (full2 !== 2'b00) begin errors++; $display("FAIL nf_full: got %b want 00", full2); end
  endtask

  task automatic test_overflow();
    auto_rel = 1'b0;
    pulse_arm();
    send_frame(5, 1'b1, -1, -1, 1'b0);
    send_frame(7, 1'b1, -1, -1, 1'b0);
    for (int f = 0; f < 3; f++) send_frame(4, 1'b0, -1, -1, 1'b0);
    checks++;
    if (dropped !== 16'd3) begin errors++; $display("FAIL ovf_drop: got %0d want 3", dropped); end
    checks++;
    if (full !== 2'b11) begin errors++; $display("FAIL ovf_full: got %b want 11", full); end
    rel_man = 2'b01; step(); rel_man = 2'b00; repeat (Gap) step();
    checks++;
    if (full !== 2'b10) begin errors++; $display("FAIL ovf_rel: got %b want 10", full); end
    send_frame(6, 1'b1, -1, -1, 1'b0);
    checks++;
    if (dropped !== 16'd3) begin errors++; $display("FAIL ovf_drop2: got %0d want 3", dropped); end
    disarm = 1'b1; step(); disarm = 1'b0; repeat (2) step();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL ovf_idle: got busy %b want 0", busy); end
    rel_man = 2'b11; step(); rel_man = 2'b00; step();
    auto_rel = 1'b1;
  endtask

  task automatic test_mid_frame_trigger();
    send_frame(6, 1'b0, 0, -1, 1'b0);
    send_frame(6, 1'b1, -1, -1, 1'b1);
  endtask

  task automatic test_disarm();
    int t0;
    send_frame(6, 1'b1, -1, 3, 1'b0);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL dis_cap_idle: got busy %b want 0", busy); end
    t0 = trig_cnt;
    pulse_arm();
    checks++;
    if (trig_cnt != t0 + 1) begin
      errors++; $display("FAIL dis_trig: got %0d want %0d", trig_cnt, t0 + 1);
    end
    disarm = 1'b1; step(); disarm = 1'b0;
    send_frame(5, 1'b1, -1, -1, 1'b0);
    send_frame(3, 1'b0, -1, -1, 1'b0);
    checks++;
    if (busy !== 1'b0 || trig_cnt != t0 + 1) begin
      errors++; $display("FAIL dis_armed: got busy %b trig %0d want 0/%0d", busy, trig_cnt, t0 + 1);
    end
  endtask

  task automatic test_reset_mid_capture();
    logic [31:0] w;
    pulse_arm();
    for (int i = 0; i < 8; i++) begin
      w = $urandom;
      tvalid = 1'b1; tdata = w; tlast = (i == 7);
      aresetn = (i != 3);
      arm = (i == 5);
      step();
      aresetn = 1'b1; arm = 1'b0;
      if (i == 3) begin
        next_bank = 1'b0;
        checks++;
        if ({trig, sel, full, len0, len1, irq, dropped, busy} !== '0) begin
          errors++;
          $display("FAIL rst_mid: got %h want 0", {trig, sel, full, len0, len1, irq, dropped, busy});
        end
      end
    end
    tvalid = 1'b0; tlast = 1'b0;
    repeat (Gap) step();
    send_frame(8, 1'b1, -1, -1, 1'b0);
  endtask

  initial begin
    tvalid = 1'b0; tready = 1'b1; tlast = 1'b0; tdata = '0;
    arm = 1'b0; disarm = 1'b0; arm2 = 1'b0; rel_man = 2'b00; aresetn = 1'b0;
    test_reset();
    test_no_arm();
    test_num_frames();
    test_overflow();
    test_mid_frame_trigger();
    test_disarm();
    test_reset_mid_capture();
    repeat (4) step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL sb_missing_irq: got %0d pending want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
